// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU sharing arbiter: operation bundle, result FIFO entry and
// the core configuration record passed through the arbiter.
package alu_share_arbiter_pkg;

   localparam int unsigned XLEN          = 32;
   localparam int unsigned TRANS_ID_BITS = 3;
   // Wide enough for the largest legal requester count (4).
   localparam int unsigned MAX_SRC_BITS  = 2;

   typedef struct packed {
      logic [31:0] xlen;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{xlen: 32'd32};

   typedef enum logic [3:0] {
      ADD, SUB, ANDL, ORL, XORL, EQ, NE, LTS, LTU, GES, GEU
   } fu_op;

   typedef struct packed {
      fu_op                     operation;
      logic [XLEN-1:0]          operand_a;
      logic [XLEN-1:0]          operand_b;
      logic [XLEN-1:0]          imm;
      logic [TRANS_ID_BITS-1:0] trans_id;
   } fu_data_t;

   typedef struct packed {
      logic [XLEN-1:0]          result;
      logic                     branch;
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic [MAX_SRC_BITS-1:0]  src;
   } alu_share_entry_t;

endpackage

// File: rtl/alu_share_fifo.sv
// Two-entry result FIFO between the shared ALU and writeback; flush and reset empty it.
module alu_share_fifo
   import alu_share_arbiter_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  alu_share_entry_t push_data_i,
   input  logic             pop_i,
   output logic             valid_o,
   output alu_share_entry_t head_o,
   output logic [1:0]       count_o
);

   alu_share_entry_t mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) wr_ptr_q <= ~wr_ptr_q;
         if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i && push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   always_comb begin
      valid_o = (count_q != 2'd0);
      head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
      count_o = count_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i) begin
         assert (count_q <= 2'd2)
            else $error("alu_share_fifo: count out of range");
         assert (!(push_i && count_q == 2'd2 && !pop_i))
            else $error("alu_share_fifo: push while full");
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between NR_REQ issue requesters, with a
// two-entry result FIFO toward writeback.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int unsigned NR_REQ  = 2,
   parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              flush_i,
   input  logic     [NR_REQ-1:0]             req_valid_i,
   input  fu_data_t [NR_REQ-1:0]             req_data_i,
   output logic     [NR_REQ-1:0]             req_ready_o,
   output fu_data_t                          alu_data_o,
   input  logic     [XLEN-1:0]               alu_result_i,
   input  logic                              alu_branch_res_i,
   output logic                              res_valid_o,
   input  logic                              res_ready_i,
   output logic     [XLEN-1:0]               res_result_o,
   output logic                              res_branch_o,
   output logic     [TRANS_ID_BITS-1:0]      res_trans_id_o,
   output logic     [$clog2(NR_REQ)-1:0]     res_src_o
);

   localparam int unsigned SrcW = $clog2(NR_REQ);

   logic [SrcW-1:0]  prio_q;
   logic [SrcW-1:0]  prio_d;
   logic [SrcW-1:0]  gnt_idx;
   logic             any_valid;
   logic             space;
   logic             accept;
   logic             pop;
   logic [1:0]       count;
   int unsigned      idx;
   alu_share_entry_t push_data;
   alu_share_entry_t head;

   // First valid requester scanning from prio_q upward with wrap.
   always_comb begin
      gnt_idx   = '0;
      any_valid = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < NR_REQ; k++) begin
         idx = (32'(prio_q) + k) % NR_REQ;
         if (!any_valid && req_valid_i[idx]) begin
            any_valid = 1'b1;
            gnt_idx   = SrcW'(idx);
         end
      end
   end

   always_comb begin
      pop    = res_valid_o & res_ready_i;
      space  = (count < 2'd2) | pop;
      accept = any_valid & space & ~flush_i & ~rst_i;
      prio_d = (gnt_idx == SrcW'(NR_REQ - 1)) ? '0 : gnt_idx + SrcW'(1);

      req_ready_o = '0;
      if (accept) req_ready_o[gnt_idx] = 1'b1;

      // Held even while stalled so the ALU input stays stable.
      alu_data_o = any_valid ? req_data_i[gnt_idx] : '0;

      push_data = '{result:   alu_result_i,
                    branch:   alu_branch_res_i,
                    trans_id: req_data_i[gnt_idx].trans_id,
                    src:      MAX_SRC_BITS'(gnt_idx)};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q <= '0;
      end else if (accept) begin
         prio_q <= prio_d;
      end
   end

   alu_share_fifo u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .push_i      (accept),
      .push_data_i (push_data),
      .pop_i       (pop),
      .valid_o     (res_valid_o),
      .head_o      (head),
      .count_o     (count)
   );

   always_comb begin
      res_result_o   = head.result;
      res_branch_o   = head.branch;
      res_trans_id_o = head.trans_id;
      res_src_o      = head.src[SrcW-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (NR_REQ >= 2 && NR_REQ <= 4)
            else $error("alu_share_arbiter: NR_REQ out of range");
         assert (CVA6Cfg.xlen == XLEN)
            else $error("alu_share_arbiter: XLEN mismatch with configuration");
         assert ($onehot0(req_ready_o))
            else $error("alu_share_arbiter: multiple ready bits");
         assert (32'(head.src) < NR_REQ)
            else $error("alu_share_arbiter: head source out of range");
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised bench for alu_share_arbiter against a queue-based model, plus directed
// scenarios with literal expectations.
module tb_alu_share_arbiter;
   import alu_share_arbiter_pkg::*;

   localparam int NR = 2;
   localparam int SW = $clog2(NR);

   logic                      clk;
   logic                      rst;
   logic                      flush;
   logic [NR-1:0]             req_valid;
   fu_data_t [NR-1:0]         req_data;
   logic [NR-1:0]             req_ready;
   fu_data_t                  alu_data;
   logic [XLEN-1:0]           alu_result;
   logic                      alu_branch;
   logic                      res_valid;
   logic                      res_ready;
   logic [XLEN-1:0]           res_result;
   logic                      res_branch;
   logic [TRANS_ID_BITS-1:0]  res_trans_id;
   logic [SW-1:0]             res_src;

   int n_vec  = 0;
   int n_miss = 0;

   alu_share_arbiter #(
      .NR_REQ  (NR),
      .CVA6Cfg (cva6_cfg_empty)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .flush_i          (flush),
      .req_valid_i      (req_valid),
      .req_data_i       (req_data),
      .req_ready_o      (req_ready),
      .alu_data_o       (alu_data),
      .alu_result_i     (alu_result),
      .alu_branch_res_i (alu_branch),
      .res_valid_o      (res_valid),
      .res_ready_i      (res_ready),
      .res_result_o     (res_result),
      .res_branch_o     (res_branch),
      .res_trans_id_o   (res_trans_id),
      .res_src_o        (res_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: returns {branch, result}.
   function automatic logic [XLEN:0] alu_fn(input fu_data_t d);
      logic [XLEN-1:0] a, b;
      a = d.operand_a;
      b = d.operand_b;
      case (d.operation)
         ADD:     return {1'b0, a + b};
         SUB:     return {1'b0, a - b};
         ANDL:    return {1'b0, a & b};
         ORL:     return {1'b0, a | b};
         XORL:    return {1'b0, a ^ b};
         EQ:      return {a == b, 31'd0, a == b};
         NE:      return {a != b, 31'd0, a != b};
         LTS:     return {$signed(a) < $signed(b), 31'd0, $signed(a) < $signed(b)};
         LTU:     return {a < b, 31'd0, a < b};
         GES:     return {$signed(a) >= $signed(b), 31'd0, $signed(a) >= $signed(b)};
         GEU:     return {a >= b, 31'd0, a >= b};
         default: return '0;
      endcase
   endfunction

   always_comb {alu_branch, alu_result} = alu_fn(alu_data);

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   function automatic fu_data_t mk(input fu_op op, input int a, input int b, input int tid);
      fu_data_t d;
      d.operation = op;
      d.operand_a = XLEN'(a);
      d.operand_b = XLEN'(b);
      d.imm       = '0;
      d.trans_id  = TRANS_ID_BITS'(tid);
      return d;
   endfunction

   function automatic fu_data_t rand_data();
      fu_data_t d;
      d.operation = fu_op'($urandom_range(0, 10));
      d.operand_a = $urandom;
      d.operand_b = ($urandom_range(0, 3) == 0) ? d.operand_a : $urandom;
      d.imm       = $urandom;
      d.trans_id  = TRANS_ID_BITS'($urandom);
      return d;
   endfunction

   // Model: priority pointer and an ordered list of pending results.
   int               m_prio = 0;
   alu_share_entry_t m_q[$];

   always @(negedge clk) begin : compare
      int               g;
      bit               any;
      bit               space;
      bit               acc;
      bit               do_pop;
      int               n;
      logic [NR-1:0]    exp_rdy;
      fu_data_t         exp_alu;
      alu_share_entry_t hd;
      logic [XLEN:0]    r;

      any = 1'b0;
      g   = 0;
      for (int k = 0; k < NR; k++) begin
         if (!any && req_valid[(m_prio + k) % NR]) begin
            any = 1'b1;
            g   = (m_prio + k) % NR;
         end
      end
      n       = m_q.size();
      do_pop  = (n > 0) && res_ready;
      space   = (n < 2) || do_pop;
      acc     = any && space && !flush && !rst;
      exp_rdy = acc ? NR'(1 << g) : '0;
      exp_alu = any ? req_data[g] : '0;
      hd      = (n > 0) ? m_q[0] : '0;

      check("req_ready", 128'(req_ready), 128'(exp_rdy));
      check("alu_data", 128'(alu_data), 128'(exp_alu));
      check("res_valid", 128'(res_valid), 128'(n > 0));
      check("res_result", 128'(res_result), 128'(hd.result));
      check("res_branch", 128'(res_branch), 128'(hd.branch));
      check("res_trans_id", 128'(res_trans_id), 128'(hd.trans_id));
      check("res_src", 128'(res_src), 128'(hd.src));

      if (rst) begin
         m_prio = 0;
         m_q.delete();
      end else if (flush) begin
         m_q.delete();
      end else begin
         if (do_pop) void'(m_q.pop_front());
         if (acc) begin
            r = alu_fn(req_data[g]);
            m_q.push_back('{result: r[XLEN-1:0], branch: r[XLEN],
                            trans_id: req_data[g].trans_id, src: MAX_SRC_BITS'(g)});
            m_prio = (g + 1) % NR;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      res_ready = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check("reset_res_valid", 128'(res_valid), 128'(0));
      check("reset_req_ready", 128'(req_ready), 128'(0));
      check("reset_alu_data", 128'(alu_data), 128'(0));
      tick();
      rst = 1'b0;

      // Single requester: ADD 3+4, trans_id 5.
      req_valid   = 2'b01;
      req_data[0] = mk(ADD, 3, 4, 5);
      res_ready   = 1'b1;
      @(negedge clk);
      check("single_ready", 128'(req_ready), 128'(2'b01));
      tick();
      req_valid = '0;
      @(negedge clk);
      check("single_valid", 128'(res_valid), 128'(1));
      check("single_result", 128'(res_result), 128'(7));
      check("single_tid", 128'(res_trans_id), 128'(5));
      check("single_src", 128'(res_src), 128'(0));
      tick();

      // Round-robin with both valid; pointer now sits at 1.
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         req_data[0] = rand_data();
         req_data[1] = rand_data();
         @(negedge clk);
         check("rr_grant", 128'(req_ready), 128'((i % 2 == 0) ? 2'b10 : 2'b01));
         tick();
      end
      req_valid = '0;
      tick();
      tick();

      // Backpressure: two accepts fill the FIFO, then stall on requester 1.
      res_ready   = 1'b0;
      req_valid   = 2'b11;
      req_data[0] = mk(SUB, 10, 3, 1);
      req_data[1] = mk(XORL, 6, 5, 2);
      tick();
      tick();
      @(negedge clk);
      check("bp_stall_ready", 128'(req_ready), 128'(0));
      check("bp_stall_alu", 128'(alu_data), 128'(req_data[1]));
      tick();
      res_ready   = 1'b1;
      req_data[1] = mk(EQ, 9, 9, 3);
      @(negedge clk);
      check("bp_accept_ready", 128'(req_ready), 128'(2'b10));
      check("bp_head_src", 128'(res_src), 128'(1));
      check("bp_head_result", 128'(res_result), 128'(3));
      tick();
      req_valid = '0;
      @(negedge clk);
      check("pp_head_src", 128'(res_src), 128'(0));
      check("pp_head_result", 128'(res_result), 128'(7));
      tick();
      @(negedge clk);
      check("pp_eq_branch", 128'(res_branch), 128'(1));
      check("pp_eq_tid", 128'(res_trans_id), 128'(3));
      tick();

      // Flush at count 2 with a valid request.
      res_ready = 1'b0;
      req_valid = 2'b11;
      tick();
      tick();
      flush = 1'b1;
      @(negedge clk);
      check("flush_ready", 128'(req_ready), 128'(0));
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("flush_valid", 128'(res_valid), 128'(0));
      check("flush_grant", 128'(req_ready), 128'(2'b01));
      tick();

      // Reset with one entry held and requests pending.
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready", 128'(req_ready), 128'(0));
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", 128'(res_valid), 128'(0));
      check("rst_grant", 128'(req_ready), 128'(2'b01));
      tick();

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         req_valid   = NR'($urandom);
         req_data[0] = rand_data();
         req_data[1] = rand_data();
         res_ready   = ($urandom_range(0, 3) != 0);
         flush       = ($urandom_range(0, 39) == 0);
         rst         = ($urandom_range(0, 149) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one combinational integer ALU (operand/operation bundle in, result and branch flag out) between NR_REQ issue requesters. Each cycle it picks one valid requester round-robin, drives its fu_data_t bundle into the ALU, and captures result, branch flag, trans_id and source index in a 2-entry result FIFO toward writeback. Sits between the issue stage ports and the shared ALU instance inside the execute stage.

## Interface
- NR_REQ, default 2: number of requesters; legal range 2..4.
- CVA6Cfg, default config_pkg::cva6_cfg_empty: core configuration, passed through.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  drops all FIFO contents; same-cycle acceptance is suppressed.
- req_valid_i  in  NR_REQ  per-requester request valid.
- req_data_i  in  NR_REQ x fu_data_t  per-requester operation, operands and trans_id.
- req_ready_o  out  NR_REQ  per-requester accept; at most one bit high.
- alu_data_o  out  fu_data_t  bundle driven to the shared ALU; the granted requester's data, else '0.
- alu_result_i  in  XLEN  ALU result, combinational from alu_data_o.
- alu_branch_res_i  in  1  ALU branch comparison result.
- res_valid_o  out  1  FIFO head valid.
- res_ready_i  in  1  writeback consumes the head.
- res_result_o  out  XLEN  head result.
- res_branch_o  out  1  head branch flag.
- res_trans_id_o  out  TRANS_ID_BITS  head trans_id.
- res_src_o  out  clog2(NR_REQ)  head source requester index.

## Operation
- Priority pointer prio_q (clog2(NR_REQ) bits). The grant goes to the first valid requester scanning prio_q, prio_q+1, … with wrap modulo NR_REQ.
- Accept is space-qualified:
  - space = (count_q < 2) | (res_valid_o & res_ready_i).
  - req_ready_o[g] = req_valid_i[g] & space & ~flush_i & ~rst_i for the granted g only.
- alu_data_o carries the granted requester's bundle whenever any request is valid, even when space is 0. This keeps the ALU input stable while stalled.
- On accept:
  - Push {alu_result_i, alu_branch_res_i, req_data_i[g].trans_id, g} at the FIFO tail.
  - prio_q <= (g+1) mod NR_REQ.
- With no accept, prio_q holds. A stalled requester keeps its grant because the pointer does not move.
- FIFO is 2 entries: write pointer, read pointer, count_q ∈ {0,1,2}.
  - Pop when res_valid_o & res_ready_i.
  - Push and pop in the same cycle: count unchanged, ordering preserved.
  - At count 2, push is allowed only with a same-cycle pop.
  - Pointers wrap 1→0.
- Overflow and underflow are impossible by construction; assertions check count_q ≤ 2 and no push while full without a pop.
- Flush:
  - count_q, rd_ptr and wr_ptr are cleared to 0.
  - No push occurs that cycle.
  - prio_q is unchanged.
  - res_valid_o is 0 from the next cycle.
- Reset (rst_i=1 at the edge): prio_q=0, count_q=0, pointers=0. Reset asserted mid-stall discards everything. No request is accepted while rst_i=1.

## Timing
- Accept in cycle N gives res_valid_o=1 in cycle N+1 if the FIFO was empty. Latency is 1 cycle.
- Sustained throughput is one accept per cycle while writeback keeps res_ready_i high.
- Combinational paths:
  - req_valid_i → req_ready_o, alu_data_o.
  - res_ready_i → req_ready_o.
  - No path from alu_result_i to any output.
- Reset values of outputs: res_valid_o=0, req_ready_o=0, res_result_o/res_branch_o/res_trans_id_o/res_src_o=0, alu_data_o='0 when no request is valid.
- Head data is stable while res_valid_o=1 and res_ready_i=0.

## Structure
- The result entry typedef (result, branch, trans_id, src) belongs in ariane_pkg next to fu_data_t. NR_REQ stays local.
- One sub-module is natural: alu_share_fifo, the 2-entry entry FIFO with push/pop/flush and count.
- Grant logic and prio_q live in the top module.

## Test plan
- Single requester: req_valid_i=01, data ADD 3+4, trans_id 5. Required: ready in the same cycle; next cycle res_valid_o=1, result 7, trans_id 5, src 0.
- Round-robin: both requesters continuously valid, res_ready_i=1. Required: grants 0,1,0,1 on consecutive cycles; results in grant order.
- Backpressure: res_ready_i=0 with three requests. Required:
  - Two accepts, then req_ready_o=0 while the granted requester's bundle stays on alu_data_o.
  - After res_ready_i=1 for one cycle, the third request is accepted in that same cycle.
- Simultaneous push and pop at count 2: FIFO order and count are preserved. Branch EQ with a=b gives res_branch_o=1.
- Flush with count 2 and a valid request: no ready that cycle; res_valid_o=0 next cycle; prio_q unchanged, so the next grant goes to the same requester.
- Reset asserted with count 1 and requests pending: res_valid_o=0 after the edge and first grant to requester 0.
